// File: rtl/max_exp_window_if.sv
// Beat/result handshake bundle between the exponent-window controller and its
// producer (master) and the alignment stage it feeds.
interface max_exp_window_if #(
    parameter int EXP_W = 6,
    parameter int CNT_W = 8
);
    logic                 start;
    logic [CNT_W-1:0]     num_beats;
    logic                 in_valid;
    logic                 in_ready;
    logic [8:0]           skip;
    logic [9*EXP_W-1:0]   exp_bus;
    logic                 out_valid;
    logic                 out_ready;
    logic [EXP_W-1:0]     max_exp;
    logic [CNT_W+3:0]     active_cnt;
    logic                 busy;

    modport master (
        output start, num_beats, in_valid, skip, exp_bus, out_ready,
        input  in_ready, out_valid, max_exp, active_cnt, busy
    );

    modport slave (
        input  start, num_beats, in_valid, skip, exp_bus, out_ready,
        output in_ready, out_valid, max_exp, active_cnt, busy
    );
endinterface

// File: rtl/max_exp_window_ctrl.sv
// Multi-beat 9-lane exponent maximum with active-lane count and result handshake.
// Optional macro MAX_EXP_PIPE_EN adds a register stage after the lane-pair compare level.
module max_exp_window_ctrl #(
    parameter int EXP_W = 6,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    max_exp_window_if.slave       bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] ONE_BEAT = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [EXP_W-1:0] max2(input logic [EXP_W-1:0] a,
                                              input logic [EXP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [3:0] popcnt9(input logic [8:0] v);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + {3'd0, v[i]};
        end
        return sum;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   beats_left_q, beats_left_d;
    logic [EXP_W-1:0]   run_max_q, run_max_d;
    logic [CNT_W+3:0]   run_cnt_q, run_cnt_d;
    logic [EXP_W-1:0]   max_exp_q, max_exp_d;
    logic [CNT_W+3:0]   active_cnt_q, active_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               drain_q, drain_d;

    logic [EXP_W-1:0]   lane_s [9];
    logic [EXP_W-1:0]   pair_s [4];
    logic [3:0]         beat_cnt_s;
    logic               accept_s;
    logic               last_accept_s;
    logic               fold_vld_s;
    logic               fold_last_s;
    logic [EXP_W-1:0]   fold_max_s;
    logic [3:0]         fold_cnt_s;

    // Skipped lanes are forced to zero, then reduced to lane-pair maxima plus lane 9.
    always_comb begin
        for (int j = 0; j < 9; j++) begin
            lane_s[j] = bus.skip[j] ? {EXP_W{1'b0}} : bus.exp_bus[j*EXP_W +: EXP_W];
        end
        pair_s[0]  = max2(lane_s[8], lane_s[7]);
        pair_s[1]  = max2(lane_s[6], lane_s[5]);
        pair_s[2]  = max2(lane_s[4], lane_s[3]);
        pair_s[3]  = max2(lane_s[2], lane_s[1]);
        beat_cnt_s = popcnt9(~bus.skip);
    end

    assign accept_s      = bus.in_valid && in_ready_q && (state_q == S_ACCUM);
    assign last_accept_s = accept_s && (beats_left_q == ONE_BEAT);

`ifdef MAX_EXP_PIPE_EN
    logic [EXP_W-1:0]   pipe_pair_q [4];
    logic [EXP_W-1:0]   pipe_pair_d [4];
    logic [EXP_W-1:0]   pipe_l9_q, pipe_l9_d;
    logic [3:0]         pipe_cnt_q, pipe_cnt_d;
    logic               pipe_vld_q, pipe_vld_d;
    logic               pipe_last_q, pipe_last_d;

    // Stage inputs: the pair level and popcount travel with a valid/last tag.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pipe_pair_d[k] = pair_s[k];
        end
        pipe_l9_d   = lane_s[0];
        pipe_cnt_d  = beat_cnt_s;
        pipe_vld_d  = accept_s;
        pipe_last_d = last_accept_s;
    end

    // Register stage between the pair compare level and the final reduction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                pipe_pair_q[k] <= {EXP_W{1'b0}};
            end
            pipe_l9_q   <= {EXP_W{1'b0}};
            pipe_cnt_q  <= 4'd0;
            pipe_vld_q  <= 1'b0;
            pipe_last_q <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                pipe_pair_q[k] <= pipe_pair_d[k];
            end
            pipe_l9_q   <= pipe_l9_d;
            pipe_cnt_q  <= pipe_cnt_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    assign fold_vld_s  = pipe_vld_q;
    assign fold_last_s = pipe_last_q;
    assign fold_cnt_s  = pipe_cnt_q;
    assign fold_max_s  = max2(max2(max2(pipe_pair_q[0], pipe_pair_q[1]),
                                   max2(pipe_pair_q[2], pipe_pair_q[3])), pipe_l9_q);
`else
    assign fold_vld_s  = accept_s;
    assign fold_last_s = last_accept_s;
    assign fold_cnt_s  = beat_cnt_s;
    assign fold_max_s  = max2(max2(max2(pair_s[0], pair_s[1]),
                                   max2(pair_s[2], pair_s[3])), lane_s[0]);
`endif

    // Window FSM: running max/count, beat countdown and result capture.
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        run_max_d    = run_max_q;
        run_cnt_d    = run_cnt_q;
        max_exp_d    = max_exp_q;
        active_cnt_d = active_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_ACCUM;
                    beats_left_d = (bus.num_beats == {CNT_W{1'b0}}) ? ONE_BEAT : bus.num_beats;
                    run_max_d    = {EXP_W{1'b0}};
                    run_cnt_d    = {(CNT_W+4){1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (accept_s) begin
                    beats_left_d = beats_left_q - ONE_BEAT;
                end else begin
                    beats_left_d = beats_left_q;
                end
                if (fold_vld_s) begin
                    run_max_d = max2(run_max_q, fold_max_s);
                    run_cnt_d = run_cnt_q + {{CNT_W{1'b0}}, fold_cnt_s};
                end else begin
                    run_max_d = run_max_q;
                    run_cnt_d = run_cnt_q;
                end
                if (fold_last_s) begin
                    state_d      = S_HOLD;
                    max_exp_d    = run_max_d;
                    active_cnt_d = run_cnt_d;
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flags are registered from the next state so they align with it.
    always_comb begin
`ifdef MAX_EXP_PIPE_EN
        if (last_accept_s) begin
            drain_d = 1'b1;
        end else if (fold_last_s || (state_q != S_ACCUM)) begin
            drain_d = 1'b0;
        end else begin
            drain_d = drain_q;
        end
`else
        drain_d = 1'b0;
`endif
        in_ready_d  = (state_d == S_ACCUM) && !drain_d;
        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beats_left_q <= {CNT_W{1'b0}};
            run_max_q    <= {EXP_W{1'b0}};
            run_cnt_q    <= {(CNT_W+4){1'b0}};
            max_exp_q    <= {EXP_W{1'b0}};
            active_cnt_q <= {(CNT_W+4){1'b0}};
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            drain_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            run_max_q    <= run_max_d;
            run_cnt_q    <= run_cnt_d;
            max_exp_q    <= max_exp_d;
            active_cnt_q <= active_cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            drain_q      <= drain_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.max_exp    = max_exp_q;
    assign bus.active_cnt = active_cnt_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/max_exp_window_ctrl.md
Name: max_exp_window_ctrl

Overview:
- Sequences the 9-lane exponent max tree across a multi-beat accumulation window (e.g. input channels of one output pixel).
- Accepts one 9-exponent beat per handshake, applies the per-lane skip mask, and keeps a running window maximum and a count of active lanes.
- Presents the window result to the alignment/shift stage of the MAC subsystem through a valid/ready handshake.
- Contains its own 9-input max reduction. Skipped lanes are forced to 0 before comparison.

Parameters:
- EXP_W, 6, exponent width per lane (FP16 exponent plus one extension bit).
- CNT_W, 8, width of the beat counter and of num_beats.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a window. Honoured only in IDLE.
- num_beats  in  CNT_W  beats in the window; sampled on the accepted start. A value of 0 is treated as 1.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat ready.
- skip  in  9  per-lane skip. skip[8] maps to lane 1 (MSB lane), skip[0] to lane 9.
- exp_bus  in  9*EXP_W  lane exponents. Lane 1 occupies the MSBs, lane 9 the LSBs.
- out_valid  out  1  window result valid.
- out_ready  in  1  result accepted.
- max_exp  out  EXP_W  window maximum exponent.
- active_cnt  out  CNT_W+4  total non-skipped lanes in the window.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE.
  - in_ready, out_valid, busy = 0.
  - max_exp, active_cnt, beat counter, running max = 0.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 → ACCUM.
  - On that edge: latch beats_left = (num_beats==0 ? 1 : num_beats); clear running max and count.
- ACCUM:
  - in_ready = 1.
  - Beat accepted when in_valid & in_ready.
  - beat_max = max over lanes i of (skip_i ? 0 : exp_i). beat_max = 0 if all lanes are skipped.
  - run_max <= max(run_max, beat_max), unsigned compare.
  - run_cnt <= run_cnt + popcount(~skip).
  - beats_left decrements on each accepted beat.
  - On acceptance with beats_left==1 → HOLD.
- HOLD:
  - in_ready = 0.
  - out_valid = 1 starting the cycle after the last beat is accepted (latency 1).
  - max_exp and active_cnt are registered and stable while out_valid is high.
  - out_valid & out_ready → IDLE. out_valid drops the next cycle; max_exp and active_cnt hold their last values.
- start outside IDLE is ignored, including start coinciding with an out_ready handshake in HOLD.
- in_valid outside ACCUM is ignored; no state change.
- Back-pressure: out_ready may stay low indefinitely. No new beats are accepted until the result is taken.
- Ties are resolved by value only; lane identity is not tracked.
- Arithmetic cannot overflow:
  - run_max is a max, so it is bounded by the lane values.
  - active_cnt ≤ 9·(2^CNT_W−1), which fits in CNT_W+4 bits.
- Reset asserted mid-window: immediate return to IDLE, outputs cleared, partial window discarded.

Optional Feature:
- Macro: MAX_EXP_PIPE_EN.
- Defined:
  - One register stage between the lane-pair compare level (4 pair maxima plus lane 9) and the final reduction.
  - beat_max and popcount are delayed one cycle together with a valid tag.
  - in_ready in ACCUM deasserts after the last beat is accepted.
  - FSM enters HOLD once the tagged last beat leaves the stage; out_valid asserts 2 cycles after the last acceptance.
  - Reset clears the stage and its tag.
- Undefined: single-cycle combinational reduction, latency 1 as above.

Test Plan:
- Reset then start, num_beats=1. One beat, exps 3,7,1,0,5,2,9,4,6, skip=0 → out_valid after 1 cycle (2 with MAX_EXP_PIPE_EN); max_exp=9; active_cnt=9.
- num_beats=3. Beat maxima 12, 30, 17; skip=9'b000000001 on every beat → max_exp=30; active_cnt=24.
- Single beat, lane 9 exp=31, all other lanes 10, skip=9'b000000001 → max_exp=10, active_cnt=8. All lanes skipped → max_exp=0, active_cnt=0.
- out_ready held low 20 cycles in HOLD with in_valid=1 and start pulses → in_ready=0, out_valid and max_exp stable, no restart. Raising out_ready → IDLE, busy=0.
- num_beats=0 → window completes after exactly one accepted beat.
- rst_n pulsed low after 2 of 4 beats → outputs 0 immediately. A new window (num_beats=1, max lane exp 5) then yields max_exp=5 with no residue from the aborted window.
